// File: rtl/fifo_pkg.sv
// Shared width helpers for the N-to-1 FIFO and its storage.
package fifo_pkg;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_nto1_reg_file_multi.sv
// Storage array with several independent write lanes and one asynchronous read port.
module reg_file_multi #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int LANES = 2
) (
  input  logic                     clk,
  input  logic [LANES-1:0]         i_we,
  input  logic [LANES-1:0][AW-1:0] i_waddr,
  input  logic [LANES*DW-1:0]      i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic [DW-1:0]            o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Lane addresses within one write never collide, so lane order is irrelevant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr[i]] <= i_wdata[i*DW +: DW];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_nto1.sv
// First-word-fall-through FIFO: up to WR_WORDS words pushed per cycle, one popped.
module fifo_nto1
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int WR_WORDS   = 2,
  localparam int CW        = cnt_width(WR_WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [CW-1:0]                w_count,
  input  logic [WR_WORDS*DATA_WIDTH-1:0] w_data,
  input  logic                         rd,
  output logic [DATA_WIDTH-1:0]        r_data,
  output logic                         empty,
  output logic                         full,
  output logic [ADDR_WIDTH:0]          count,
  output logic [ADDR_WIDTH:0]          space,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int CMPW  = max_int(CW, PW) + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_ovf;
  logic          r_udf;

  logic [PW-1:0]   w_occ;
  logic            w_rd_ok;
  logic            w_wr_ok;
  logic [CMPW-1:0] w_req;
  logic [CMPW-1:0] w_room;
  logic [WR_WORDS-1:0]                 w_lane_en;
  logic [WR_WORDS-1:0][ADDR_WIDTH-1:0] w_lane_addr;

  assign w_occ = r_wptr - r_rptr;
  assign count = w_occ;
  assign empty = (w_occ == PW'(0));
  assign full  = (w_occ == PW'(DEPTH));
  assign space = PW'(DEPTH) - w_occ;

  // A same-cycle accepted read frees one slot, so it counts toward the room.
  assign w_rd_ok = rd & ~empty;
  assign w_req   = CMPW'(w_count);
  assign w_room  = CMPW'(space) + CMPW'(w_rd_ok);
  assign w_wr_ok = wr & (w_count != CW'(0)) & (w_req <= CMPW'(WR_WORDS)) & (w_req <= w_room);

  // Per-lane enables and wrapped addresses for an accepted write.
  always_comb begin
    w_lane_en   = '0;
    w_lane_addr = '0;
    for (int i = 0; i < WR_WORDS; i++) begin
      w_lane_en[i]   = w_wr_ok & (CMPW'(i) < w_req);
      w_lane_addr[i] = r_wptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
    end
  end

  // Pointer advance and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PW'(w_count);
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_ovf <= wr & (w_count != CW'(0)) & ~w_wr_ok;
      r_udf <= rd & empty;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;

  reg_file_multi #(
    .DW    (DATA_WIDTH),
    .AW    (ADDR_WIDTH),
    .LANES (WR_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_lane_en),
    .i_waddr (w_lane_addr),
    .i_wdata (w_data),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (r_data)
  );

endmodule

// File: tb/tb_fifo_nto1.sv
// Randomized and directed bench for fifo_nto1 against a queue-based reference model.
module tb_fifo_nto1;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int WW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          wr;
  logic [1:0]    w_count;
  logic [15:0]   w_data;
  logic          rd;
  logic [7:0]    r_data;
  logic          empty;
  logic          full;
  logic [2:0]    count;
  logic [2:0]    space;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q[$];
  logic       exp_ovf;
  logic       exp_udf;

  fifo_nto1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WR_WORDS(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .w_count   (w_count),
    .w_data    (w_data),
    .rd        (rd),
    .r_data    (r_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .space     (space),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("space", 32'(space), 32'(DEPTH - q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_udf));
    if (q.size() != 0) check("r_data", 32'(r_data), 32'(q[0]));
  endtask

  // One clock with the given inputs, then model update and full comparison.
  task automatic step(input logic i_wr, input logic [1:0] i_wc, input logic [15:0] i_wd,
                      input logic i_rd);
    bit rd_ok, wr_ok;
    int room;
    wr = i_wr; w_count = i_wc; w_data = i_wd; rd = i_rd; reset = 1'b0;
    @(posedge clk);
    #1;
    rd_ok = i_rd && (q.size() > 0);
    room  = DEPTH - q.size() + (rd_ok ? 1 : 0);
    wr_ok = i_wr && (i_wc >= 1) && (i_wc <= WW) && (int'(i_wc) <= room);
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) for (int i = 0; i < int'(i_wc); i++) q.push_back(i_wd[i*8 +: 8]);
    exp_ovf = i_wr && (i_wc != 2'd0) && !wr_ok;
    exp_udf = i_rd && !rd_ok;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b1; w_count = 2'd1; w_data = 16'h00FF; rd = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; w_count = 2'd0; w_data = 16'h0000; rd = 1'b0;
    exp_ovf = 1'b0; exp_udf = 1'b0;

    // Reset then idle
    do_reset();
    step(1'b0, 2'd0, 16'h0000, 1'b0);
    check("s1_space", 32'(space), 32'd4);

    // Two-word write then two reads
    step(1'b1, 2'd2, 16'hB2A1, 1'b0);
    check("s2_head0", 32'(r_data), 32'h0A1);
    step(1'b0, 2'd0, 16'h0000, 1'b1);
    check("s2_head1", 32'(r_data), 32'h0B2);
    step(1'b0, 2'd0, 16'h0000, 1'b1);
    check("s2_empty", 32'(empty), 32'd1);

    // Overflow, then same write accepted thanks to a same-cycle read
    step(1'b1, 2'd2, 16'h0201, 1'b0);
    step(1'b1, 2'd1, 16'h0003, 1'b0);
    step(1'b1, 2'd2, 16'h0504, 1'b0);
    check("s3_ovf", 32'(overflow), 32'd1);
    check("s3_cnt", 32'(count), 32'd3);
    step(1'b1, 2'd2, 16'h0504, 1'b1);
    check("s3_full", 32'(full), 32'd1);
    check("s3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 16'h0000, 1'b1);

    // Wrap across the last address
    do_reset();
    step(1'b1, 2'd2, 16'h0C0B, 1'b0);
    step(1'b1, 2'd1, 16'h000D, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'h0000, 1'b1);
    step(1'b1, 2'd2, 16'h2211, 1'b0);
    check("s4_head0", 32'(r_data), 32'h011);
    step(1'b0, 2'd0, 16'h0000, 1'b1);
    check("s4_head1", 32'(r_data), 32'h022);
    step(1'b0, 2'd0, 16'h0000, 1'b1);

    // Read while empty with simultaneous write
    step(1'b1, 2'd1, 16'h005A, 1'b1);
    check("s5_udf", 32'(underflow), 32'd1);
    check("s5_data", 32'(r_data), 32'h05A);

    // Reset with pending write at count 3
    step(1'b1, 2'd2, 16'h7766, 1'b0);
    check("s6_cnt3", 32'(count), 32'd3);
    do_reset();
    check("s6_empty", 32'(empty), 32'd1);

    // Randomized traffic including w_count=0 and w_count above WR_WORDS
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
             1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
